// File: rtl/program_sequencer_if.sv
// Handshake bundle between the instruction decoder (master) and the
// program sequencer (slave). Breakpoint signals exist only when the
// PC_BREAKPOINT_EN macro is defined.
interface program_sequencer_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic [2:0]        cmd;
    logic [ADDR_W-1:0] address_in;
    logic              err_clr;
    logic [ADDR_W-1:0] address_out;
    logic [LVL_W-1:0]  stack_level;
    logic              stack_ovf;
    logic              stack_unf;
`ifdef PC_BREAKPOINT_EN
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_en;
    logic              resume;
    logic              halted;
`endif

`ifdef PC_BREAKPOINT_EN
    modport master (output cmd, address_in, err_clr, bp_addr, bp_en, resume,
                    input  address_out, stack_level, stack_ovf, stack_unf, halted);
    modport slave  (input  cmd, address_in, err_clr, bp_addr, bp_en, resume,
                    output address_out, stack_level, stack_ovf, stack_unf, halted);
`else
    modport master (output cmd, address_in, err_clr,
                    input  address_out, stack_level, stack_ovf, stack_unf);
    modport slave  (input  cmd, address_in, err_clr,
                    output address_out, stack_level, stack_ovf, stack_unf);
`endif
endinterface

// File: rtl/program_sequencer.sv
// Program sequencer: fetch-address generator with INC/HOLD/JMP/CALL/RTN/SKIP
// commands, an internal LIFO return stack and sticky overflow/underflow flags.
// All state changes on the falling edge of clk; rst is asynchronous active-low.
// Optional breakpoint/halt logic is enabled with the PC_BREAKPOINT_EN macro.
module program_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input logic               clk,
    input logic               rst,
    program_sequencer_if.slave bus
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    // Pointer width into the stack array; at least one bit so depth 1 works.
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        CMD_INC  = 3'b000,
        CMD_HOLD = 3'b001,
        CMD_JMP  = 3'b010,
        CMD_CALL = 3'b011,
        CMD_RTN  = 3'b100,
        CMD_SKIP = 3'b101
    } cmd_e;

    logic [ADDR_W-1:0] pc, pc_next, pc_inc;
    logic [ADDR_W-1:0] stack [2**PTR_W];
    logic [LVL_W-1:0]  level, level_next;
    logic [PTR_W-1:0]  push_idx, top_idx;
    logic              push, ovf_set, unf_set, run;
    logic              ovf, unf;

    // The stack level doubles as the write pointer; the top entry sits one below.
    assign push_idx = level[PTR_W-1:0];
    assign top_idx  = push_idx - PTR_W'(1);
    assign pc_inc   = pc + ADDR_W'(1);

`ifdef PC_BREAKPOINT_EN
    logic halted, bp_armed, trigger;

    // A hit freezes the sequencer in the same cycle it is detected.
    assign trigger = bus.bp_en && !halted && bp_armed && (pc == bus.bp_addr);
    assign run     = halted ? bus.resume : !trigger;

    // Halt state and re-arm tracking: re-arm only after the PC has moved.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            halted   <= 1'b0;
            bp_armed <= 1'b1;
        end else begin
            if (trigger) begin
                halted   <= 1'b1;
                bp_armed <= 1'b0;
            end else begin
                if (halted && bus.resume) halted <= 1'b0;
                if (pc_next != pc)        bp_armed <= 1'b1;
            end
        end
    end

    assign bus.halted = halted;
`else
    assign run = 1'b1;
`endif

    // Next-state decode of the sequencer command.
    always_comb begin
        // NOTE: every output of this block is defaulted first so that no path leaves a latch.
        pc_next    = pc;
        level_next = level;
        push       = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (run) begin
            case (bus.cmd)
                CMD_HOLD: pc_next = pc;
                CMD_JMP:  pc_next = bus.address_in;
                CMD_CALL: begin
                    if (level == FULL) begin
                        pc_next = pc_inc;
                        ovf_set = 1'b1;
                    end else begin
                        push       = 1'b1;
                        pc_next    = bus.address_in;
                        level_next = level + LVL_W'(1);
                    end
                end
                CMD_RTN: begin
                    if (level == '0) begin
                        pc_next = pc_inc;
                        unf_set = 1'b1;
                    end else begin
                        pc_next    = stack[top_idx];
                        level_next = level - LVL_W'(1);
                    end
                end
                CMD_SKIP: pc_next = pc + ADDR_W'(2);
                default:  pc_next = pc_inc;   // INC and the two spare codes
            endcase
        end
    end

    // PC, stack level and sticky error flags.
    always_ff @(negedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            pc    <= RESET_ADDR;
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            pc    <= pc_next;
            level <= level_next;
            if (run) begin
                // A new error in the clearing cycle wins over err_clr.
                ovf <= (ovf & ~bus.err_clr) | ovf_set;
                unf <= (unf & ~bus.err_clr) | unf_set;
            end
        end
    end

    // Return-address storage; only the stack level marks entries valid.
    always_ff @(negedge clk) begin
        // NOTE: the stack array is deliberately not reset; stale entries are unreachable once level is 0.
        if (push) stack[push_idx] <= pc_inc;
    end

    assign bus.address_out = pc;
    assign bus.stack_level = level;
    assign bus.stack_ovf   = ovf;
    assign bus.stack_unf   = unf;
endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer (ADDR_W=8, STACK_DEPTH=4).
// Inputs change 1 ns after each falling edge; outputs are sampled 1 ns after it.
module tb_program_sequencer;
    localparam logic [2:0] INC  = 3'b000;
    localparam logic [2:0] HOLD = 3'b001;
    localparam logic [2:0] JMP  = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RTN  = 3'b100;
    localparam logic [2:0] SKIP = 3'b101;

    typedef struct packed {
        logic [2:0] cmd;
        logic [7:0] addr;
        logic       clr;
        logic [7:0] pc;
        logic [2:0] lvl;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    program_sequencer_if #(.ADDR_W(8), .STACK_DEPTH(4)) bus ();

    program_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        bus.cmd = INC; bus.address_in = 8'h00; bus.err_clr = 1'b0;
`ifdef PC_BREAKPOINT_EN
        bus.bp_addr = 8'h00; bus.bp_en = 1'b0; bus.resume = 1'b0;
`endif
        rst = 1'b0;
        @(negedge clk); #1;
        total++;
        if ({bus.address_out, bus.stack_level, bus.stack_ovf, bus.stack_unf} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got pc=%h lvl=%0d ovf=%b unf=%b, want pc=00 lvl=0 ovf=0 unf=0",
                     bus.address_out, bus.stack_level, bus.stack_ovf, bus.stack_unf);
        end
        rst = 1'b1;
    endtask

    task automatic test_increment;
        for (int i = 1; i <= 5; i++) begin
            bus.cmd = INC;
            @(negedge clk); #1;
            total++;
            if (bus.address_out !== 8'(i)) begin
                bad++;
                $display("FAIL inc_%0d: got pc=%h, want %h", i, bus.address_out, 8'(i));
            end
        end
        // Asynchronous reset mid-run, no clock edge in between.
        rst = 1'b0;
        #1;
        total++;
        if (bus.address_out !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: got pc=%h, want 00", bus.address_out);
        end
        #1 rst = 1'b1;
    endtask

    task automatic test_wrap;
        vec_t v [11];
        v = '{'{JMP,  8'hFE, 1'b0, 8'hFE, 3'd0, 1'b0, 1'b0},
              '{INC,  8'h00, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0},
              '{INC,  8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0},
              '{SKIP, 8'h00, 1'b0, 8'h02, 3'd0, 1'b0, 1'b0},
              '{JMP,  8'hFE, 1'b0, 8'hFE, 3'd0, 1'b0, 1'b0},
              '{SKIP, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0},
              '{JMP,  8'hFF, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0},
              '{SKIP, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0},
              '{JMP,  8'hFF, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0},
              '{CALL, 8'h80, 1'b0, 8'h80, 3'd1, 1'b0, 1'b0},
              '{RTN,  8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}};
        foreach (v[i]) begin
            bus.cmd = v[i].cmd; bus.address_in = v[i].addr; bus.err_clr = v[i].clr;
            @(negedge clk); #1;
            total++;
            if ({bus.address_out, bus.stack_level, bus.stack_ovf, bus.stack_unf} !== {v[i].pc, v[i].lvl, v[i].ovf, v[i].unf}) begin
                bad++;
                $display("FAIL wrap_%0d: got pc=%h lvl=%0d ovf=%b unf=%b, want pc=%h lvl=%0d ovf=%b unf=%b", i,
                         bus.address_out, bus.stack_level, bus.stack_ovf, bus.stack_unf, v[i].pc, v[i].lvl, v[i].ovf, v[i].unf);
            end
        end
        bus.err_clr = 1'b0;
    endtask

    task automatic test_call_return;
        vec_t v [5];
        v = '{'{JMP,  8'h10, 1'b0, 8'h10, 3'd0, 1'b0, 1'b0},
              '{CALL, 8'h40, 1'b0, 8'h40, 3'd1, 1'b0, 1'b0},
              '{INC,  8'h00, 1'b0, 8'h41, 3'd1, 1'b0, 1'b0},
              '{INC,  8'h00, 1'b0, 8'h42, 3'd1, 1'b0, 1'b0},
              '{RTN,  8'h00, 1'b0, 8'h11, 3'd0, 1'b0, 1'b0}};
        foreach (v[i]) begin
            bus.cmd = v[i].cmd; bus.address_in = v[i].addr; bus.err_clr = v[i].clr;
            @(negedge clk); #1;
            total++;
            if ({bus.address_out, bus.stack_level, bus.stack_ovf, bus.stack_unf} !== {v[i].pc, v[i].lvl, v[i].ovf, v[i].unf}) begin
                bad++;
                $display("FAIL call_rtn_%0d: got pc=%h lvl=%0d ovf=%b unf=%b, want pc=%h lvl=%0d ovf=%b unf=%b", i,
                         bus.address_out, bus.stack_level, bus.stack_ovf, bus.stack_unf, v[i].pc, v[i].lvl, v[i].ovf, v[i].unf);
            end
        end
        bus.err_clr = 1'b0;
    endtask

    task automatic test_overflow;
        vec_t v [11];
        v = '{'{JMP,  8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0},
              '{CALL, 8'h20, 1'b0, 8'h20, 3'd1, 1'b0, 1'b0},
              '{CALL, 8'h30, 1'b0, 8'h30, 3'd2, 1'b0, 1'b0},
              '{CALL, 8'h40, 1'b0, 8'h40, 3'd3, 1'b0, 1'b0},
              '{CALL, 8'h50, 1'b0, 8'h50, 3'd4, 1'b0, 1'b0},
              '{CALL, 8'h60, 1'b0, 8'h51, 3'd4, 1'b1, 1'b0},
              '{RTN,  8'h00, 1'b0, 8'h41, 3'd3, 1'b1, 1'b0},
              '{RTN,  8'h00, 1'b0, 8'h31, 3'd2, 1'b1, 1'b0},
              '{RTN,  8'h00, 1'b0, 8'h21, 3'd1, 1'b1, 1'b0},
              '{RTN,  8'h00, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0},
              '{HOLD, 8'h00, 1'b1, 8'h01, 3'd0, 1'b0, 1'b0}};
        foreach (v[i]) begin
            bus.cmd = v[i].cmd; bus.address_in = v[i].addr; bus.err_clr = v[i].clr;
            @(negedge clk); #1;
            total++;
            if ({bus.address_out, bus.stack_level, bus.stack_ovf, bus.stack_unf} !== {v[i].pc, v[i].lvl, v[i].ovf, v[i].unf}) begin
                bad++;
                $display("FAIL overflow_%0d: got pc=%h lvl=%0d ovf=%b unf=%b, want pc=%h lvl=%0d ovf=%b unf=%b", i,
                         bus.address_out, bus.stack_level, bus.stack_ovf, bus.stack_unf, v[i].pc, v[i].lvl, v[i].ovf, v[i].unf);
            end
        end
        bus.err_clr = 1'b0;
    endtask

    task automatic test_underflow;
        vec_t v [6];
        v = '{'{JMP,  8'h07, 1'b0, 8'h07, 3'd0, 1'b0, 1'b0},
              '{RTN,  8'h00, 1'b0, 8'h08, 3'd0, 1'b0, 1'b1},
              '{HOLD, 8'h00, 1'b1, 8'h08, 3'd0, 1'b0, 1'b0},
              '{RTN,  8'h00, 1'b1, 8'h09, 3'd0, 1'b0, 1'b1},
              '{HOLD, 8'h00, 1'b0, 8'h09, 3'd0, 1'b0, 1'b1},
              '{3'b111, 8'h00, 1'b1, 8'h0A, 3'd0, 1'b0, 1'b0}};
        foreach (v[i]) begin
            bus.cmd = v[i].cmd; bus.address_in = v[i].addr; bus.err_clr = v[i].clr;
            @(negedge clk); #1;
            total++;
            if ({bus.address_out, bus.stack_level, bus.stack_ovf, bus.stack_unf} !== {v[i].pc, v[i].lvl, v[i].ovf, v[i].unf}) begin
                bad++;
                $display("FAIL underflow_%0d: got pc=%h lvl=%0d ovf=%b unf=%b, want pc=%h lvl=%0d ovf=%b unf=%b", i,
                         bus.address_out, bus.stack_level, bus.stack_ovf, bus.stack_unf, v[i].pc, v[i].lvl, v[i].ovf, v[i].unf);
            end
        end
        bus.err_clr = 1'b0;
    endtask

`ifdef PC_BREAKPOINT_EN
    task automatic test_breakpoint;
        logic [2:0] c   [7] = '{JMP,   INC,   INC,   INC,   INC,   JMP,   INC};
        logic [7:0] pc  [7] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h04};
        logic       h   [7] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
        logic       res [7] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        bus.bp_addr = 8'h03;
        for (int i = 0; i < 7; i++) begin
            bus.bp_en = (i != 0);
            bus.cmd = c[i]; bus.address_in = (i == 5) ? 8'h50 : 8'h00; bus.resume = res[i];
            @(negedge clk); #1;
            total++;
            if ({bus.address_out, bus.halted} !== {pc[i], h[i]}) begin
                bad++;
                $display("FAIL breakpoint_%0d: got pc=%h halted=%b, want pc=%h halted=%b", i,
                         bus.address_out, bus.halted, pc[i], h[i]);
            end
        end
        bus.bp_en = 1'b0; bus.resume = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_increment;
        test_wrap;
        test_call_return;
        test_overflow;
        test_underflow;
`ifdef PC_BREAKPOINT_EN
        test_breakpoint;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Parametrised successor to the single-register program counter for the MC14500B core.
- Generates the instruction fetch address and supports straight-line increment, hold, absolute jump, skip-next, and subroutine call/return through an internal LIFO return stack.
- Sits between the instruction decoder, which drives the command, and program memory, which consumes the address.
- Reports stack overflow and underflow errors to the control unit.

Parameters:
ADDR_W, 8, width of program address in bits
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_ADDR, 0, address loaded on reset (ADDR_W bits)

Ports:
clk  input  1  system clock; all state updates on the falling edge
rst  input  1  asynchronous active-low reset
cmd  input  3  sequencer command, sampled on the falling edge of clk
address_in  input  ADDR_W  target address for JMP/CALL
err_clr  input  1  clears sticky error flags
address_out  output  ADDR_W  current program address
stack_level  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
stack_ovf  output  1  sticky: CALL attempted with stack full
stack_unf  output  1  sticky: RTN attempted with stack empty

Behaviour:
- Reset (rst=0, asynchronous):
  - address_out=RESET_ADDR, stack_level=0, stack_ovf=0, stack_unf=0.
  - Stack contents are don't-care.
  - Deassertion takes effect at the next falling edge.
  - Reset mid-operation discards any pending command.
- Command encoding. Each command is applied on a falling edge with rst=1; the new value is visible after that edge (1-cycle latency):
  - 000 INC: PC <= PC+1.
  - 001 HOLD: PC unchanged.
  - 010 JMP: PC <= address_in.
  - 011 CALL: push PC+1, then PC <= address_in, stack_level+1.
  - 100 RTN: PC <= top of stack, pop, stack_level-1.
  - 101 SKIP: PC <= PC+2.
  - 110, 111: treated as INC.
- Arithmetic:
  - All PC arithmetic is modulo 2^ADDR_W; no carry out.
  - Wrap examples (ADDR_W=8): 0xFF INC -> 0x00; 0xFE SKIP -> 0x00; 0xFF SKIP -> 0x01.
  - A pushed return address of PC+1 also wraps (CALL at 0xFF pushes 0x00).
- Stack full, CALL with stack_level==STACK_DEPTH:
  - No push and no jump.
  - PC <= PC+1.
  - stack_ovf <= 1.
- Stack empty, RTN with stack_level==0:
  - No pop.
  - PC <= PC+1.
  - stack_unf <= 1.
- Stack organisation:
  - Strict LIFO; entries are not shifted.
  - Stack pointer indexes the register array.
- Error flags:
  - Sticky until err_clr=1 at a falling edge, which clears both flags.
  - If err_clr coincides with a new error in the same cycle, the flag ends up set (set wins).
  - err_clr has no effect on PC or stack.
- Output timing:
  - address_out is a direct register output with no combinational path from cmd or address_in.
  - stack_level is registered.

Optional Feature:
Macro PC_BREAKPOINT_EN.
- Defined:
  - Adds ports bp_addr (input, ADDR_W), bp_en (input, 1), resume (input, 1) and halted (output, 1, reset 0).
  - At a falling edge with bp_en=1, halted=0 and address_out==bp_addr, halted <= 1.
  - While halted=1, every cmd is treated as HOLD, and the stack and error flags are frozen.
  - resume=1 at a falling edge clears halted and executes that cycle's cmd normally.
  - The breakpoint does not re-trigger on the same address until address_out has changed once.
  - Reset clears halted.
- Undefined:
  - Ports absent; behaviour as above with no halting.

Test Plan:
1. Reset then 5x INC (ADDR_W=8) -> address_out 0x00,01,02,03,04,05; async rst=0 mid-run -> address_out=0x00 immediately, no clock needed.
2. PC=0xFE, INC, INC, SKIP -> 0xFF, 0x00, 0x02; PC=0xFE, SKIP -> 0x00.
3. PC=0x10, CALL 0x40, then INC x2, then RTN -> 0x40, 0x41, 0x42, 0x11; stack_level 0->1->1->1->0.
4. STACK_DEPTH=4: nested CALLs 0x20,0x30,0x40,0x50 from 0x00, then fifth CALL 0x60 -> PC=0x51, stack_ovf=1, stack_level=4; four RTNs return 0x41,0x31,0x21,0x01.
5. Empty stack, PC=0x07, RTN -> PC=0x08, stack_unf=1; err_clr with no error -> stack_unf=0; err_clr coinciding with RTN on empty stack -> stack_unf stays 1.
6. PC_BREAKPOINT_EN, bp_addr=0x03, bp_en=1, INC from 0x00 -> halts at 0x03, halted=1, PC holds under INC/JMP; resume with INC -> 0x04, halted=0.
